// File: rtl/bpm_estimator.sv
// rtl/bpm_estimator.sv - beat interval to BPM estimator with restoring divider
// Optional exponential smoothing of the estimate: BPM_SMOOTH_EN.
module bpm_estimator #(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int MAX_BPM        = 200,
  parameter int TIMEOUT_CYCLES = 2 * CLK_FREQ_HZ,
  parameter int DIV_W          = 32,
  parameter int BPM_W          = $clog2(MAX_BPM + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             beat_in,
  output logic [BPM_W-1:0] bpm_estimate,
  output logic             bpm_valid,
  output logic             locked,
  output logic             busy
);

  localparam longint NUM_L        = 64'(60) * 64'(CLK_FREQ_HZ);
  localparam longint MIN_INTERVAL = NUM_L / MAX_BPM;
  localparam int     CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int     STEP_W       = $clog2(DIV_W);

  localparam logic [DIV_W-1:0]  NUM       = DIV_W'(NUM_L);
  localparam logic [DIV_W-1:0]  MAX_Q     = DIV_W'(MAX_BPM);
  localparam logic [CNT_W-1:0]  MIN_CNT   = CNT_W'(MIN_INTERVAL);
  localparam logic [CNT_W-1:0]  TIMEOUT   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DIV_W - 1);

  typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE, UPDATE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DIV_W-1:0]    rem_q, rem_d;
  logic [DIV_W-1:0]    quo_q, quo_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [BPM_W-1:0]    bpm_q, bpm_d;
  logic                valid_q, valid_d;
  logic                locked_q, locked_d;
  logic                busy_q, busy_d;

  logic [CNT_W-1:0]    cnt_inc;
  logic                beat_ok;
  logic [DIV_W:0]      rem_shift;
  logic [BPM_W-1:0]    result;
`ifdef BPM_SMOOTH_EN
  logic [BPM_W+1:0]    smooth_sum;
`endif

  // cnt_q counts cycles elapsed since the last accepted beat, so it equals the interval on the next beat
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    step_d    = step_q;
    bpm_d     = bpm_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    cnt_inc   = (cnt_q == TIMEOUT) ? cnt_q : cnt_q + CNT_W'(1);
    beat_ok   = beat_in && (cnt_q >= MIN_CNT);
    rem_shift = {rem_q, quo_q[DIV_W-1]};
    result    = (quo_q > MAX_Q) ? BPM_W'(MAX_BPM) : quo_q[BPM_W-1:0];
`ifdef BPM_SMOOTH_EN
    smooth_sum = {2'b00, bpm_q} + {1'b0, bpm_q, 1'b0} + {2'b00, result} + (BPM_W+2)'(2);
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (beat_in) begin
          cnt_d   = CNT_W'(1);
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        cnt_d = cnt_inc;
        if (beat_ok) begin
          cnt_d   = CNT_W'(1);
          div_d   = DIV_W'(cnt_q);
          rem_d   = '0;
          quo_d   = NUM;
          step_d  = '0;
          state_d = DIVIDE;
        end else if (cnt_q == TIMEOUT) begin
          cnt_d    = '0;
          bpm_d    = '0;
          locked_d = 1'b0;
          valid_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      DIVIDE: begin
        cnt_d = beat_ok ? CNT_W'(1) : cnt_inc;
        // quo_q shifts the dividend out of its top while quotient bits enter at the bottom
        if (rem_shift >= {1'b0, div_q}) begin
          rem_d = DIV_W'(rem_shift - {1'b0, div_q});
          quo_d = {quo_q[DIV_W-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[DIV_W-1:0];
          quo_d = {quo_q[DIV_W-2:0], 1'b0};
        end
        step_d = step_q + STEP_W'(1);
        if (step_q == LAST_STEP) state_d = UPDATE;
      end
      UPDATE: begin
        cnt_d = beat_ok ? CNT_W'(1) : cnt_inc;
`ifdef BPM_SMOOTH_EN
        bpm_d = locked_q ? smooth_sum[BPM_W+1:2] : result;
`else
        bpm_d = result;
`endif
        valid_d  = 1'b1;
        locked_d = 1'b1;
        state_d  = MEASURE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == DIVIDE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      step_q   <= '0;
      bpm_q    <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      step_q   <= step_d;
      bpm_q    <= bpm_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      busy_q   <= busy_d;
    end
  end

  assign bpm_estimate = bpm_q;
  assign bpm_valid    = valid_q;
  assign locked       = locked_q;
  assign busy         = busy_q;

endmodule
